// File: rtl/occamy_spi_axi_lite_arbiter.sv
// Round-robin sharing of one AXI-Lite master port between the SPI bridge (req 0) and the
// debug/boot requester (req 1). Optional response watchdog: define ARB_TIMEOUT_EN.

typedef struct packed {
   logic [31:0] addr;
   logic [2:0]  prot;
} occamy_arb_ax_chan_t;

typedef struct packed {
   logic [31:0] data;
   logic [3:0]  strb;
} occamy_arb_w_chan_t;

typedef struct packed {
   logic [1:0] resp;
} occamy_arb_b_chan_t;

typedef struct packed {
   logic [31:0] data;
   logic [1:0]  resp;
} occamy_arb_r_chan_t;

typedef struct packed {
   occamy_arb_ax_chan_t aw;
   logic                aw_valid;
   occamy_arb_w_chan_t  w;
   logic                w_valid;
   logic                b_ready;
   occamy_arb_ax_chan_t ar;
   logic                ar_valid;
   logic                r_ready;
} occamy_arb_req_t;

typedef struct packed {
   logic               aw_ready;
   logic               w_ready;
   occamy_arb_b_chan_t b;
   logic               b_valid;
   logic               ar_ready;
   occamy_arb_r_chan_t r;
   logic               r_valid;
} occamy_arb_resp_t;

module occamy_spi_axi_lite_arbiter #(
   parameter type axi_lite_req_t  = occamy_arb_req_t,
   parameter type axi_lite_resp_t = occamy_arb_resp_t,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  axi_lite_req_t  [1:0] req_i,
   output axi_lite_resp_t [1:0] rsp_o,
   output axi_lite_req_t        mst_req_o,
   input  axi_lite_resp_t       mst_rsp_i,
   output logic [1:0]           grant_o,
   output logic                 busy_o,
   output logic                 timeout_o
);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD_ADDR,
      RD_DATA
`ifdef ARB_TIMEOUT_EN
      ,
      DRAIN
`endif
   } state_e;

   state_e        state_q;
   logic          owner_q;
   logic          rrPtr_q;
   logic          awDone_q;
   logic          wDone_q;
   logic          busy_q;
   logic [1:0]    grant_q;

   logic [1:0]    pending;
   logic          winner;
   logic          winnerWrites;
   logic          awDone_d;
   logic          wDone_d;
   logic          awHs;
   logic          wHs;
   logic          bHs;
   logic          rHs;
   logic          respHs;
   axi_lite_req_t selReq;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
   logic [CntW-1:0] cnt_q;
   logic            cntExpired;
   logic            errResp_q;
   logic            timeout_q;
   logic            errHs;

   // While the error response is presented, the requester's ready alone completes it.
   assign cntExpired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign errHs      = (state_q == WR_RESP) ? selReq.b_ready : selReq.r_ready;
   assign timeout_o  = timeout_q;
`else
   assign timeout_o  = 1'b0;
`endif

   assign selReq   = req_i[owner_q];
   assign grant_o  = grant_q;
   assign busy_o   = busy_q;

   assign awHs     = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
   assign wHs      = mst_req_o.w_valid & mst_rsp_i.w_ready;
   assign bHs      = mst_rsp_i.b_valid & mst_req_o.b_ready;
   assign rHs      = mst_rsp_i.r_valid & mst_req_o.r_ready;
   assign respHs   = (state_q == WR_RESP) ? bHs : rHs;
   assign awDone_d = awDone_q | awHs;
   assign wDone_d  = wDone_q | wHs;

   // The round-robin pointer holder wins if pending; otherwise the other requester does.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         pending[i] = (req_i[i].aw_valid & req_i[i].w_valid) | req_i[i].ar_valid;
      end
      winner       = pending[rrPtr_q] ? rrPtr_q : ~rrPtr_q;
      winnerWrites = req_i[winner].aw_valid & req_i[winner].w_valid;
   end

   // Forward the granted requester's channels to the crossbar and route responses back to it only.
   always_comb begin
      mst_req_o = '0;
      rsp_o     = '0;
      if (state_q != IDLE) begin
         mst_req_o.aw = selReq.aw;
         mst_req_o.w  = selReq.w;
         mst_req_o.ar = selReq.ar;
      end
      case (state_q)
         WR: begin
            mst_req_o.aw_valid      = selReq.aw_valid & ~awDone_q;
            mst_req_o.w_valid       = selReq.w_valid & ~wDone_q;
            rsp_o[owner_q].aw_ready = mst_rsp_i.aw_ready & ~awDone_q;
            rsp_o[owner_q].w_ready  = mst_rsp_i.w_ready & ~wDone_q;
         end
         WR_RESP: begin
            rsp_o[owner_q].b       = mst_rsp_i.b;
            rsp_o[owner_q].b_valid = mst_rsp_i.b_valid;
            mst_req_o.b_ready      = selReq.b_ready;
`ifdef ARB_TIMEOUT_EN
            if (errResp_q) begin
               rsp_o[owner_q].b       = '0;
               rsp_o[owner_q].b.resp  = 2'b10;
               rsp_o[owner_q].b_valid = 1'b1;
               mst_req_o.b_ready      = 1'b0;
            end
`endif
         end
         RD_ADDR: begin
            mst_req_o.ar_valid      = selReq.ar_valid;
            rsp_o[owner_q].ar_ready = mst_rsp_i.ar_ready;
         end
         RD_DATA: begin
            rsp_o[owner_q].r       = mst_rsp_i.r;
            rsp_o[owner_q].r_valid = mst_rsp_i.r_valid;
            mst_req_o.r_ready      = selReq.r_ready;
`ifdef ARB_TIMEOUT_EN
            if (errResp_q) begin
               rsp_o[owner_q].r       = '0;
               rsp_o[owner_q].r.data  = 32'hDEAD_BEEF;
               rsp_o[owner_q].r.resp  = 2'b10;
               rsp_o[owner_q].r_valid = 1'b1;
               mst_req_o.r_ready      = 1'b0;
            end
`endif
         end
`ifdef ARB_TIMEOUT_EN
         DRAIN: begin
            mst_req_o.b_ready = 1'b1;
            mst_req_o.r_ready = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Arbitration, transaction sequencing and the optional watchdog, all synchronous to clk_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         rrPtr_q   <= 1'b0;
         awDone_q  <= 1'b0;
         wDone_q   <= 1'b0;
         busy_q    <= 1'b0;
         grant_q   <= 2'b00;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
         errResp_q <= 1'b0;
         timeout_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
               cnt_q <= '0;
`endif
               if (|pending) begin
                  owner_q  <= winner;
                  rrPtr_q  <= ~winner;
                  grant_q  <= winner ? 2'b10 : 2'b01;
                  busy_q   <= 1'b1;
                  awDone_q <= 1'b0;
                  wDone_q  <= 1'b0;
                  state_q  <= winnerWrites ? WR : RD_ADDR;
               end
            end
            WR: begin
               awDone_q <= awDone_d;
               wDone_q  <= wDone_d;
               if (awDone_d && wDone_d) begin
                  state_q <= WR_RESP;
               end
            end
            RD_ADDR: begin
               if (mst_req_o.ar_valid && mst_rsp_i.ar_ready) begin
                  state_q <= RD_DATA;
               end
            end
            WR_RESP, RD_DATA: begin
`ifdef ARB_TIMEOUT_EN
               if (errResp_q) begin
                  if (errHs) begin
                     state_q   <= DRAIN;
                     errResp_q <= 1'b0;
                     cnt_q     <= '0;
                  end
               end else if (respHs) begin
                  state_q <= IDLE;
                  grant_q <= 2'b00;
                  busy_q  <= 1'b0;
               end else if (cntExpired) begin
                  errResp_q <= 1'b1;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
`else
               if (respHs) begin
                  state_q <= IDLE;
                  grant_q <= 2'b00;
                  busy_q  <= 1'b0;
               end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            DRAIN: begin
               if (bHs || rHs || cntExpired) begin
                  state_q <= IDLE;
                  grant_q <= 2'b00;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_occamy_spi_axi_lite_arbiter.sv
// Directed bench for occamy_spi_axi_lite_arbiter; the watchdog scenario runs when ARB_TIMEOUT_EN is defined.

module tb_occamy_spi_axi_lite_arbiter;

   logic                   clk = 1'b0;
   logic                   rst;
   occamy_arb_req_t  [1:0] req;
   occamy_arb_resp_t [1:0] rsp;
   occamy_arb_req_t        mstReq;
   occamy_arb_resp_t       mstRsp;
   logic [1:0]             grant;
   logic                   busy;
   logic                   timeout;
   int                     checks = 0;
   int                     failures = 0;

   always #5 clk = ~clk;

   occamy_spi_axi_lite_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .rsp_o     (rsp),
      .mst_req_o (mstReq),
      .mst_rsp_i (mstRsp),
      .grant_o   (grant),
      .busy_o    (busy),
      .timeout_o (timeout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearAll();
      req    = '0;
      mstRsp = '0;
   endtask

   task automatic test_reset();
      logic [4:0] mstCtl;
      #1;
      checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL reset_grant got=%b exp=00", grant); end
      checks++; if ({busy, timeout} !== 2'b00) begin failures++; $display("[TB] FAIL reset_busy_timeout got=%b exp=00", {busy, timeout}); end
      mstCtl = {mstReq.aw_valid, mstReq.w_valid, mstReq.ar_valid, mstReq.b_ready, mstReq.r_ready};
      checks++; if (mstCtl !== 5'b0) begin failures++; $display("[TB] FAIL reset_mst_ctl got=%b exp=00000", mstCtl); end
      checks++; if (rsp !== '0) begin failures++; $display("[TB] FAIL reset_rsp got=%h exp=0", rsp); end
      req[0].aw.addr  = 32'h0000_0040;
      req[0].aw_valid = 1'b1;
      req[0].w.data   = 32'h0000_0001;
      req[0].w.strb   = 4'hF;
      req[0].w_valid  = 1'b1;
      req[0].b_ready  = 1'b1;
      tick();
      mstRsp.aw_ready = 1'b1;
      mstRsp.w_ready  = 1'b1;
      tick();
      mstRsp.aw_ready = 1'b0;
      mstRsp.w_ready  = 1'b0;
      req[0].aw_valid = 1'b0;
      req[0].w_valid  = 1'b0;
      #1;
      checks++; if ({busy, mstReq.b_ready} !== 2'b11) begin failures++; $display("[TB] FAIL reset_pre_wrresp got=%b exp=11", {busy, mstReq.b_ready}); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if ({grant, busy} !== 3'b000) begin failures++; $display("[TB] FAIL reset_mid_grant_busy got=%b exp=000", {grant, busy}); end
      mstCtl = {mstReq.aw_valid, mstReq.w_valid, mstReq.ar_valid, mstReq.b_ready, mstReq.r_ready};
      checks++; if (mstCtl !== 5'b0) begin failures++; $display("[TB] FAIL reset_mid_mst_ctl got=%b exp=00000", mstCtl); end
      clearAll();
   endtask

   task automatic test_single_write();
      req[0].aw.addr  = 32'h0000_1000;
      req[0].aw_valid = 1'b1;
      req[0].w.data   = 32'hA5A5_5A5A;
      req[0].w.strb   = 4'hF;
      req[0].w_valid  = 1'b1;
      req[0].b_ready  = 1'b1;
      req[1].b_ready  = 1'b1;
      #1;
      checks++; if ({mstReq.aw_valid, mstReq.w_valid} !== 2'b00) begin failures++; $display("[TB] FAIL wr_idle_latency got=%b exp=00", {mstReq.aw_valid, mstReq.w_valid}); end
      tick();
      mstRsp.aw_ready = 1'b1;
      mstRsp.w_ready  = 1'b1;
      #1;
      checks++; if (grant !== 2'b01) begin failures++; $display("[TB] FAIL wr_grant got=%b exp=01", grant); end
      checks++; if ({mstReq.aw_valid, mstReq.w_valid} !== 2'b11) begin failures++; $display("[TB] FAIL wr_mst_valids got=%b exp=11", {mstReq.aw_valid, mstReq.w_valid}); end
      checks++; if ({mstReq.aw.addr, mstReq.w.data, mstReq.w.strb} !== {32'h0000_1000, 32'hA5A5_5A5A, 4'hF})
         begin failures++; $display("[TB] FAIL wr_payload got=%h/%h/%h exp=1000/a5a55a5a/f", mstReq.aw.addr, mstReq.w.data, mstReq.w.strb); end
      checks++; if ({rsp[0].aw_ready, rsp[0].w_ready, rsp[1].aw_ready, rsp[1].w_ready} !== 4'b1100)
         begin failures++; $display("[TB] FAIL wr_readies got=%b exp=1100", {rsp[0].aw_ready, rsp[0].w_ready, rsp[1].aw_ready, rsp[1].w_ready}); end
      tick();
      mstRsp.aw_ready = 1'b0;
      mstRsp.w_ready  = 1'b0;
      req[0].aw_valid = 1'b0;
      req[0].w_valid  = 1'b0;
      mstRsp.b_valid  = 1'b1;
      mstRsp.b.resp   = 2'b00;
      #1;
      checks++; if ({rsp[0].b_valid, rsp[0].b.resp, rsp[1].b_valid} !== 4'b1000)
         begin failures++; $display("[TB] FAIL wr_b_route got=%b exp=1000", {rsp[0].b_valid, rsp[0].b.resp, rsp[1].b_valid}); end
      checks++; if (mstReq.b_ready !== 1'b1) begin failures++; $display("[TB] FAIL wr_b_ready got=%b exp=1", mstReq.b_ready); end
      tick();
      mstRsp.b_valid = 1'b0;
      #1;
      checks++; if ({grant, busy} !== 3'b000) begin failures++; $display("[TB] FAIL wr_done_idle got=%b exp=000", {grant, busy}); end
      clearAll();
   endtask

   task automatic test_split_write();
      logic [2:0] expCtl;
      req[0].aw.addr  = 32'h0000_2000;
      req[0].aw_valid = 1'b1;
      req[0].w.data   = 32'h0BAD_F00D;
      req[0].w.strb   = 4'h3;
      req[0].w_valid  = 1'b1;
      req[0].b_ready  = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         mstRsp.aw_ready = (c == 2) || (c == 3);
         mstRsp.w_ready  = (c == 5);
         if (c == 6) begin
            req[0].aw_valid = 1'b0;
            req[0].w_valid  = 1'b0;
         end
         #1;
         expCtl = {(c >= 1 && c <= 2), (c >= 1 && c <= 5), (c == 6)};
         checks++; if ({mstReq.aw_valid, mstReq.w_valid, mstReq.b_ready} !== expCtl)
            begin failures++; $display("[TB] FAIL split_c%0d got=%b exp=%b", c, {mstReq.aw_valid, mstReq.w_valid, mstReq.b_ready}, expCtl); end
         checks++; if (rsp[0].aw_ready !== (c == 2))
            begin failures++; $display("[TB] FAIL split_awready_c%0d got=%b exp=%b", c, rsp[0].aw_ready, (c == 2)); end
         tick();
      end
      mstRsp.b_valid = 1'b1;
      tick();
      clearAll();
   endtask

   task automatic test_contention();
      logic [1:0]  expGrant [12] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2};
      logic [1:0]  expRv    [12] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2};
      logic [31:0] expAddr;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req[0].ar.addr  = 32'h0000_2000;
      req[0].ar_valid = 1'b1;
      req[0].r_ready  = 1'b1;
      req[1].ar.addr  = 32'h0000_3000;
      req[1].ar_valid = 1'b1;
      req[1].r_ready  = 1'b1;
      mstRsp.ar_ready = 1'b1;
      mstRsp.r_valid  = 1'b1;
      mstRsp.r.data   = 32'hC0DE_0001;
      for (int c = 0; c < 12; c++) begin
         #1;
         checks++; if (grant !== expGrant[c]) begin failures++; $display("[TB] FAIL rr_grant_c%0d got=%b exp=%b", c, grant, expGrant[c]); end
         checks++; if ({rsp[1].r_valid, rsp[0].r_valid} !== expRv[c])
            begin failures++; $display("[TB] FAIL rr_rvalid_c%0d got=%b exp=%b", c, {rsp[1].r_valid, rsp[0].r_valid}, expRv[c]); end
         checks++; if (mstReq.ar_valid !== (c % 3 == 1))
            begin failures++; $display("[TB] FAIL rr_arvalid_c%0d got=%b exp=%b", c, mstReq.ar_valid, (c % 3 == 1)); end
         if (c % 3 == 1) begin
            expAddr = (expGrant[c] == 2'b10) ? 32'h0000_3000 : 32'h0000_2000;
            checks++; if (mstReq.ar.addr !== expAddr) begin failures++; $display("[TB] FAIL rr_araddr_c%0d got=%h exp=%h", c, mstReq.ar.addr, expAddr); end
         end
         if (c == 2) begin
            checks++; if (rsp[0].r.data !== 32'hC0DE_0001) begin failures++; $display("[TB] FAIL rr_rdata got=%h exp=c0de0001", rsp[0].r.data); end
         end
         tick();
      end
      clearAll();
      tick();
   endtask

   task automatic test_write_priority();
      req[1].aw.addr  = 32'h0000_4000;
      req[1].aw_valid = 1'b1;
      req[1].w.data   = 32'h1111_2222;
      req[1].w.strb   = 4'hF;
      req[1].w_valid  = 1'b1;
      req[1].b_ready  = 1'b1;
      req[1].ar.addr  = 32'h0000_5000;
      req[1].ar_valid = 1'b1;
      req[1].r_ready  = 1'b1;
      tick();
      mstRsp.aw_ready = 1'b1;
      mstRsp.w_ready  = 1'b1;
      #1;
      checks++; if ({grant, mstReq.aw_valid, mstReq.ar_valid} !== 4'b1010)
         begin failures++; $display("[TB] FAIL prio_write_first got=%b exp=1010", {grant, mstReq.aw_valid, mstReq.ar_valid}); end
      checks++; if (mstReq.aw.addr !== 32'h0000_4000) begin failures++; $display("[TB] FAIL prio_awaddr got=%h exp=4000", mstReq.aw.addr); end
      tick();
      mstRsp.aw_ready = 1'b0;
      mstRsp.w_ready  = 1'b0;
      req[1].aw_valid = 1'b0;
      req[1].w_valid  = 1'b0;
      mstRsp.b_valid  = 1'b1;
      tick();
      mstRsp.b_valid = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL prio_gap got=%b exp=0", busy); end
      tick();
      mstRsp.ar_ready = 1'b1;
      #1;
      checks++; if ({grant, mstReq.ar_valid, mstReq.aw_valid} !== 4'b1010)
         begin failures++; $display("[TB] FAIL prio_read_second got=%b exp=1010", {grant, mstReq.ar_valid, mstReq.aw_valid}); end
      checks++; if (mstReq.ar.addr !== 32'h0000_5000) begin failures++; $display("[TB] FAIL prio_araddr got=%h exp=5000", mstReq.ar.addr); end
      tick();
      mstRsp.ar_ready = 1'b0;
      req[1].ar_valid = 1'b0;
      mstRsp.r_valid  = 1'b1;
      mstRsp.r.data   = 32'h1234_5678;
      #1;
      checks++; if ({rsp[1].r_valid, rsp[1].r.data, rsp[0].r_valid} !== {1'b1, 32'h1234_5678, 1'b0})
         begin failures++; $display("[TB] FAIL prio_rdata got=%b/%h/%b exp=1/12345678/0", rsp[1].r_valid, rsp[1].r.data, rsp[0].r_valid); end
      tick();
      clearAll();
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL prio_done got=%b exp=0", busy); end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic [3:0] expVec;
      req[0].ar.addr  = 32'h0000_6000;
      req[0].ar_valid = 1'b1;
      tick();
      mstRsp.ar_ready = 1'b1;
      tick();
      mstRsp.ar_ready = 1'b0;
      req[0].ar_valid = 1'b0;
      for (int t = 0; t <= 21; t++) begin
         req[0].r_ready = (t == 18);
         mstRsp.r_valid = (t == 20);
         mstRsp.r.data  = 32'h0BAD_0BAD;
         #1;
         expVec = {(t >= 16 && t <= 18), (t >= 16), (t <= 20), (t >= 19 && t <= 20)};
         checks++; if ({rsp[0].r_valid, timeout, busy, mstReq.r_ready} !== expVec)
            begin failures++; $display("[TB] FAIL wdog_t%0d got=%b exp=%b", t, {rsp[0].r_valid, timeout, busy, mstReq.r_ready}, expVec); end
         if (t == 16) begin
            checks++; if ({rsp[0].r.resp, rsp[0].r.data} !== {2'b10, 32'hDEAD_BEEF})
               begin failures++; $display("[TB] FAIL wdog_slverr got=%b/%h exp=10/deadbeef", rsp[0].r.resp, rsp[0].r.data); end
         end
         tick();
      end
      clearAll();
   endtask
`endif

   initial begin
      rst = 1'b1;
      clearAll();
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_single_write();
      test_split_write();
      test_contention();
      test_write_priority();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
